// File: rtl/ysyx_22050598_reg_read_stage.sv
// ----------------------------------------------------------------------------
// ysyx_22050598_reg_read_stage
//
// Register-read / issue stage of an in-order pipeline. It sits between decode
// and execute:
//   - drives the register-file read addresses straight from rs1/rs2;
//   - forwards same-cycle writeback data onto the operands;
//   - tracks one outstanding writer per register in a busy scoreboard and
//     stalls decode on RAW (source busy) and WAW (destination busy) hazards;
//   - holds one output entry for execute, with backpressure and flush.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       decode-side handshake
//   rs1, rs2, rd, inst_type   decoded register fields and one-hot type
//   in_pc                     pc of the incoming instruction
//   raddr1/2, rdata1/2        combinational register-file read ports
//   wb_en, wb_addr, wb_data   writeback port (regfile writes on the same edge)
//   flush                     discard the held output entry
//   out_valid / out_ready     execute-side handshake
//   out_op1/2, out_pc, out_rd, out_rd_we, out_type   held output entry
//   stall_cnt                 saturating count of hazard-stall cycles
//   dbg_busy                  current busy scoreboard, for observation
//   dbg_cnt_load/dbg_cnt_val  preload of stall_cnt, for observation of the
//                             saturation point without billions of cycles
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. A producer holding valid keeps its payload
// stable until the transfer; ready may depend combinationally on the other
// side's inputs, valid never depends on ready.
// ----------------------------------------------------------------------------
module ysyx_22050598_reg_read_stage #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int TW   = 6
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       rs1,
    input  logic [AW-1:0]       rs2,
    input  logic [AW-1:0]       rd,
    input  logic [TW-1:0]       inst_type,
    input  logic [XLEN-1:0]     in_pc,

    output logic [AW-1:0]       raddr1,
    output logic [AW-1:0]       raddr2,
    input  logic [XLEN-1:0]     rdata1,
    input  logic [XLEN-1:0]     rdata2,

    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,

    input  logic                flush,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_op1,
    output logic [XLEN-1:0]     out_op2,
    output logic [XLEN-1:0]     out_pc,
    output logic [AW-1:0]       out_rd,
    output logic                out_rd_we,
    output logic [TW-1:0]       out_type,

    output logic [31:0]         stall_cnt,

    output logic [(1<<AW)-1:0]  dbg_busy,
    input  logic                dbg_cnt_load,
    input  logic [31:0]         dbg_cnt_val
);

    localparam int NREG = 1 << AW;

    // One-hot instruction type codes.
    localparam logic [TW-1:0] TYPE_I = TW'(6'b000001);
    localparam logic [TW-1:0] TYPE_R = TW'(6'b000010);
    localparam logic [TW-1:0] TYPE_B = TW'(6'b000100);
    localparam logic [TW-1:0] TYPE_S = TW'(6'b001000);
    localparam logic [TW-1:0] TYPE_U = TW'(6'b010000);
    localparam logic [TW-1:0] TYPE_J = TW'(6'b100000);

    // Which types read rs1, read rs2, and write rd.
    localparam logic [TW-1:0] USE1_MASK = TYPE_I | TYPE_R | TYPE_B | TYPE_S;
    localparam logic [TW-1:0] USE2_MASK = TYPE_R | TYPE_B | TYPE_S;
    localparam logic [TW-1:0] RDWE_MASK = TYPE_R | TYPE_I | TYPE_U | TYPE_J;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    logic            use1;
    logic            use2;
    logic            rd_we;
    logic            wb_hit1;
    logic            wb_hit2;
    logic            wb_hit_rd;
    logic            hazard;
    logic            issue;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign raddr1 = rs1;
    assign raddr2 = rs2;

    assign use1  = |(inst_type & USE1_MASK);
    assign use2  = |(inst_type & USE2_MASK);
    assign rd_we = (|(inst_type & RDWE_MASK)) && (rd != '0);

    // A writeback landing this edge retires the busy bit it targets, so it
    // must not count as a hazard: the data is bypassed below instead.
    assign wb_hit1   = wb_en && (wb_addr == rs1);
    assign wb_hit2   = wb_en && (wb_addr == rs2);
    assign wb_hit_rd = wb_en && (wb_addr == rd);

    assign hazard = (use1  && (rs1 != '0) && busy[rs1] && !wb_hit1)
                 || (use2  && (rs2 != '0) && busy[rs2] && !wb_hit2)
                 || (rd_we && busy[rd] && !wb_hit_rd);

    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign issue    = in_valid && in_ready;

    // Operand selection: x0 and unused sources are forced to zero regardless
    // of what the register file returns.
    always_comb begin
        op1 = '0;
        op2 = '0;
        if (use1 && (rs1 != '0)) begin
            op1 = wb_hit1 ? wb_data : rdata1;
        end
        if (use2 && (rs2 != '0)) begin
            op2 = wb_hit2 ? wb_data : rdata2;
        end
    end

    // Busy scoreboard update. Clears are applied first so that a new writer
    // issued on the same edge as the old writer's writeback keeps the bit set.
    // A flushed entry will never write back, so its claim is released.
    always_comb begin
        busy_next = busy;
        if (wb_en) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (flush && out_valid && out_rd_we) begin
            busy_next[out_rd] = 1'b0;
        end
        if (issue && rd_we) begin
            busy_next[rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_pc    <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
            out_type  <= '0;
            stall_cnt <= '0;
        end else begin
            busy <= busy_next;

            if (flush) begin
                out_valid <= 1'b0;
            end else if (issue) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Payload only moves on issue, so it stays put under backpressure.
            if (issue) begin
                out_op1   <= op1;
                out_op2   <= op2;
                out_pc    <= in_pc;
                out_rd    <= rd;
                out_rd_we <= rd_we;
                out_type  <= inst_type;
            end

            if (dbg_cnt_load) begin
                stall_cnt <= dbg_cnt_val;
            end else if (in_valid && hazard && !flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign dbg_busy = busy;

endmodule

// File: tb/tb_ysyx_22050598_reg_read_stage.sv
module tb_ysyx_22050598_reg_read_stage;

    localparam logic [5:0] T_I = 6'b000001;
    localparam logic [5:0] T_R = 6'b000010;
    localparam logic [5:0] T_B = 6'b000100;
    localparam logic [5:0] T_S = 6'b001000;
    localparam logic [5:0] T_U = 6'b010000;
    localparam logic [5:0] T_J = 6'b100000;

    // Expected output entry: {op1, op2, pc, rd, rd_we, type}
    localparam int EW = 64 + 64 + 64 + 5 + 1 + 6;

    typedef struct {
        logic        in_valid;
        logic [5:0]  typ;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [63:0] wb_data;
        logic        flush;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [31:0] exp_busy;
        logic [31:0] exp_stall;
        logic [63:0] exp_op1;
        logic [63:0] exp_op2;
        logic        exp_rd_we;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  inst_type;
    logic [63:0] in_pc;
    logic [4:0]  raddr1, raddr2;
    logic [63:0] rdata1, rdata2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_op1, out_op2, out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [5:0]  out_type;
    logic [31:0] stall_cnt;
    logic [31:0] dbg_busy;
    logic        dbg_cnt_load;
    logic [31:0] dbg_cnt_val;

    always #5 clk = ~clk;

    ysyx_22050598_reg_read_stage #(.XLEN(64), .AW(5), .TW(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .inst_type(inst_type), .in_pc(in_pc),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_pc(out_pc),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_type(out_type),
        .stall_cnt(stall_cnt),
        .dbg_busy(dbg_busy), .dbg_cnt_load(dbg_cnt_load), .dbg_cnt_val(dbg_cnt_val)
    );

    // Register-file stub. Entry 0 deliberately returns a non-zero value so
    // the stage's own x0 masking is exercised.
    logic [63:0] rf [32];
    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input vec_t v);
        return {v.exp_op1, v.exp_op2, v.pc, v.rd, v.exp_rd_we, v.typ};
    endfunction

    function automatic vec_t mk(input int iv, input logic [5:0] typ, input int r1, input int r2, input int rdd,
                                input logic [63:0] pc, input int wb, input int wba, input logic [63:0] wbd,
                                input int fl, input int ordy, input int ir, input int ov,
                                input logic [31:0] busy, input logic [31:0] stall,
                                input logic [63:0] op1, input logic [63:0] op2, input int we);
        vec_t v;
        v.in_valid      = iv[0];
        v.typ           = typ;
        v.rs1           = r1[4:0];
        v.rs2           = r2[4:0];
        v.rd            = rdd[4:0];
        v.pc            = pc;
        v.wb_en         = wb[0];
        v.wb_addr       = wba[4:0];
        v.wb_data       = wbd;
        v.flush         = fl[0];
        v.out_ready     = ordy[0];
        v.exp_in_ready  = ir[0];
        v.exp_out_valid = ov[0];
        v.exp_busy      = busy;
        v.exp_stall     = stall;
        v.exp_op1       = op1;
        v.exp_op2       = op2;
        v.exp_rd_we     = we[0];
        return v;
    endfunction

    function automatic vec_t idle(input int ir, input int ov, input logic [31:0] busy, input logic [31:0] stall);
        return mk(0, 6'b0, 0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 1, ir, ov, busy, stall, 64'h0, 64'h0, 0);
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge: drives one cycle of inputs, checks the
    // pre-edge view against the vector, then advances the scoreboard on the
    // bench's own expectation of what transferred.
    task automatic run_cycle(input vec_t v, input logic r, input logic ld, input logic [31:0] ldv, input int idx);
        logic [EW-1:0] e;
        rst          = r;
        in_valid     = v.in_valid;
        inst_type    = v.typ;
        rs1          = v.rs1;
        rs2          = v.rs2;
        rd           = v.rd;
        in_pc        = v.pc;
        wb_en        = v.wb_en;
        wb_addr      = v.wb_addr;
        wb_data      = v.wb_data;
        flush        = v.flush;
        out_ready    = v.out_ready;
        dbg_cnt_load = ld;
        dbg_cnt_val  = ldv;
        #1;
        if (!r) begin
            chk("in_ready",  idx, 64'(in_ready),  64'(v.exp_in_ready));
            chk("out_valid", idx, 64'(out_valid), 64'(v.exp_out_valid));
            chk("busy",      idx, 64'(dbg_busy),  64'(v.exp_busy));
            chk("stall_cnt", idx, 64'(stall_cnt), 64'(v.exp_stall));
            chk("raddr1",    idx, 64'(raddr1),    64'(v.rs1));
            chk("raddr2",    idx, 64'(raddr2),    64'(v.rs2));
            if (v.exp_out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_entry @%0d: got out_valid with no expected entry queued", idx);
                end else begin
                    e = exp_q[0];
                    chk("out_op1",   idx, out_op1,          e[203:140]);
                    chk("out_op2",   idx, out_op2,          e[139:76]);
                    chk("out_pc",    idx, out_pc,           e[75:12]);
                    chk("out_rd",    idx, 64'(out_rd),      64'(e[11:7]));
                    chk("out_rd_we", idx, 64'(out_rd_we),   64'(e[6]));
                    chk("out_type",  idx, 64'(out_type),    64'(e[5:0]));
                end
            end
        end
        @(posedge clk);
        if (r) begin
            exp_q.delete();
        end else begin
            if (v.exp_out_valid && (v.out_ready || v.flush) && (exp_q.size() != 0)) begin
                void'(exp_q.pop_front());
            end
            if (v.in_valid && v.exp_in_ready) begin
                exp_q.push_back(pack(v));
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outs(input int idx);
        chk("rst_out_valid", idx, 64'(out_valid), 64'h0);
        chk("rst_out_op1",   idx, out_op1,        64'h0);
        chk("rst_out_op2",   idx, out_op2,        64'h0);
        chk("rst_out_pc",    idx, out_pc,         64'h0);
        chk("rst_out_rd",    idx, 64'(out_rd),    64'h0);
        chk("rst_out_rd_we", idx, 64'(out_rd_we), 64'h0);
        chk("rst_out_type",  idx, 64'(out_type),  64'h0);
        chk("rst_busy",      idx, 64'(dbg_busy),  64'h0);
        chk("rst_stall_cnt", idx, 64'(stall_cnt), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    vec_t vecs[27];

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'h100 + 64'(i);
        rf[0] = 64'hFFFF;
        rf[1] = 64'h5;
        rf[2] = 64'h7;

        //                 iv typ r1 r2 rd pc          wb wa wd        fl rdy ir ov busy    stall   op1       op2     we
        vecs[0]  = mk(1, T_R, 1, 2, 3, 64'h1000, 0, 0, 64'h0,  0, 1, 1, 0, 32'h0,  32'd0, 64'h5,  64'h7, 1);
        vecs[1]  = mk(1, T_I, 3, 0, 4, 64'h1004, 0, 0, 64'h0,  0, 1, 0, 1, 32'h8,  32'd0, 64'h0,  64'h0, 1);
        vecs[2]  = mk(1, T_I, 3, 0, 4, 64'h1004, 0, 0, 64'h0,  0, 1, 0, 0, 32'h8,  32'd1, 64'h0,  64'h0, 1);
        vecs[3]  = mk(1, T_I, 3, 0, 4, 64'h1004, 0, 0, 64'h0,  0, 1, 0, 0, 32'h8,  32'd2, 64'h0,  64'h0, 1);
        vecs[4]  = mk(1, T_I, 3, 0, 4, 64'h1004, 1, 3, 64'h2A, 0, 1, 1, 0, 32'h8,  32'd3, 64'h2A, 64'h0, 1);
        vecs[5]  = mk(1, T_I, 0, 0, 0, 64'h1008, 0, 0, 64'h0,  0, 1, 1, 1, 32'h10, 32'd3, 64'h0,  64'h0, 0);
        vecs[6]  = idle(1, 1, 32'h10, 32'd3);
        vecs[7]  = mk(1, T_S, 1, 2, 9, 64'h100C, 0, 0, 64'h0,  0, 1, 1, 0, 32'h10, 32'd3, 64'h5,  64'h7, 0);
        vecs[8]  = mk(1, T_R, 2, 1, 6, 64'h1010, 0, 0, 64'h0,  0, 0, 0, 1, 32'h10, 32'd3, 64'h7,  64'h5, 1);
        vecs[9]  = vecs[8];
        vecs[10] = vecs[8];
        vecs[11] = vecs[8];
        vecs[12] = mk(1, T_R, 2, 1, 6, 64'h1010, 0, 0, 64'h0,  0, 1, 1, 1, 32'h10, 32'd3, 64'h7,  64'h5, 1);
        vecs[13] = idle(1, 1, 32'h50, 32'd3);
        vecs[14] = mk(1, T_J, 0, 0, 5, 64'h2000, 0, 0, 64'h0,  0, 1, 1, 0, 32'h50, 32'd3, 64'h0,  64'h0, 1);
        vecs[15] = mk(0, 6'b0, 0, 0, 0, 64'h0,   0, 0, 64'h0,  1, 0, 0, 1, 32'h70, 32'd3, 64'h0,  64'h0, 0);
        vecs[16] = idle(1, 0, 32'h50, 32'd3);
        vecs[17] = mk(1, T_U, 0, 0, 5, 64'h3000, 0, 0, 64'h0,  0, 1, 1, 0, 32'h50, 32'd3, 64'h0,  64'h0, 1);
        vecs[18] = mk(1, T_R, 5, 1, 5, 64'h3004, 1, 5, 64'h77, 0, 1, 1, 1, 32'h70, 32'd3, 64'h77, 64'h5, 1);
        vecs[19] = idle(1, 1, 32'h70, 32'd3);
        vecs[20] = mk(1, T_I, 0, 0, 4, 64'h4000, 0, 0, 64'h0,  0, 1, 0, 0, 32'h70, 32'd3, 64'h0,  64'h0, 1);
        vecs[21] = mk(1, T_I, 0, 0, 4, 64'h4000, 1, 4, 64'h99, 0, 1, 1, 0, 32'h70, 32'd4, 64'h0,  64'h0, 1);
        vecs[22] = idle(1, 1, 32'h70, 32'd4);
        vecs[23] = mk(1, T_I, 0, 0, 6, 64'h4004, 0, 0, 64'h0,  1, 1, 0, 0, 32'h70, 32'd4, 64'h0,  64'h0, 1);
        vecs[24] = idle(1, 0, 32'h70, 32'd4);
        vecs[25] = mk(1, T_B, 1, 2, 7, 64'h5000, 0, 0, 64'h0,  0, 1, 1, 0, 32'h70, 32'd4, 64'h5,  64'h7, 0);
        vecs[26] = idle(1, 1, 32'h70, 32'd4);

        // Reset, then reset-state outputs.
        @(negedge clk);
        run_cycle(idle(0, 0, 32'h0, 32'd0), 1'b1, 1'b0, 32'h0, -1);
        run_cycle(idle(0, 0, 32'h0, 32'd0), 1'b1, 1'b0, 32'h0, -1);
        chk_reset_outs(-1);

        // Main table: issue, RAW stall + bypass, x0 masking, backpressure,
        // flush, same-edge wb/issue on one register, WAW stall.
        for (int i = 0; i < 27; i++) begin
            run_cycle(vecs[i], 1'b0, 1'b0, 32'h0, i);
        end

        // Reset in the middle of a stall, with flush and writeback also active.
        run_cycle(mk(1, T_I, 0, 0, 4, 64'h4008, 0, 0, 64'h0, 0, 1, 0, 0, 32'h70, 32'd4, 64'h0, 64'h0, 1), 1'b0, 1'b0, 32'h0, 100);
        run_cycle(mk(1, T_I, 0, 0, 4, 64'h4008, 1, 4, 64'h55, 1, 1, 0, 0, 32'h0, 32'd0, 64'h0, 64'h0, 1), 1'b1, 1'b0, 32'h0, 101);
        chk_reset_outs(101);
        run_cycle(idle(1, 0, 32'h0, 32'd0), 1'b0, 1'b0, 32'h0, 102);

        // stall_cnt preloaded near the top, then driven into saturation.
        run_cycle(mk(1, T_I, 0, 0, 8, 64'h6000, 0, 0, 64'h0, 0, 1, 1, 0, 32'h0,   32'd0,         64'h0, 64'h0, 1), 1'b0, 1'b1, 32'hFFFF_FFFD, 200);
        run_cycle(mk(1, T_I, 0, 0, 8, 64'h6004, 0, 0, 64'h0, 0, 1, 0, 1, 32'h100, 32'hFFFF_FFFD, 64'h0, 64'h0, 1), 1'b0, 1'b0, 32'h0, 201);
        run_cycle(mk(1, T_I, 0, 0, 8, 64'h6004, 0, 0, 64'h0, 0, 1, 0, 0, 32'h100, 32'hFFFF_FFFE, 64'h0, 64'h0, 1), 1'b0, 1'b0, 32'h0, 202);
        run_cycle(mk(1, T_I, 0, 0, 8, 64'h6004, 0, 0, 64'h0, 0, 1, 0, 0, 32'h100, 32'hFFFF_FFFF, 64'h0, 64'h0, 1), 1'b0, 1'b0, 32'h0, 203);
        run_cycle(mk(1, T_I, 0, 0, 8, 64'h6004, 0, 0, 64'h0, 0, 1, 0, 0, 32'h100, 32'hFFFF_FFFF, 64'h0, 64'h0, 1), 1'b0, 1'b0, 32'h0, 204);
        run_cycle(idle(1, 0, 32'h100, 32'hFFFF_FFFF), 1'b0, 1'b0, 32'h0, 205);

        chk("queue_drained", 999, 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050598_reg_read_stage.md
YSYX_22050598_REG_READ_STAGE -- requirements
Module: ysyx_22050598_reg_read_stage

Interface
REQ-001 Parameter XLEN, default 64, operand/data width.
REQ-002 Parameter AW, default 5, register address width; NREG = 2^AW registers, register 0 hardwired zero.
REQ-003 Parameter TW, default 6, instruction-type width; type codes one-hot: I=6'b000001, R=6'b000010, B=6'b000100, S=6'b001000, U=6'b010000, J=6'b100000.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1; in_ready  out  1: decode-side handshake.
REQ-007 rs1, rs2, rd  in  AW each; inst_type  in  TW; in_pc  in  XLEN.
REQ-008 raddr1, raddr2  out  AW; rdata1, rdata2  in  XLEN: combinational register-file read ports.
REQ-009 wb_en  in  1; wb_addr  in  AW; wb_data  in  XLEN: writeback port (same-cycle regfile write).
REQ-010 flush  in  1  discard held output entry.
REQ-011 out_valid  out  1; out_ready  in  1: execute-side handshake.
REQ-012 out_op1, out_op2, out_pc  out  XLEN; out_rd  out  AW; out_rd_we  out  1; out_type  out  TW.
REQ-013 stall_cnt  out  32  saturating count of hazard-stall cycles.

Function
REQ-014 raddr1=rs1, raddr2=rs2 at all times (combinational).
REQ-015 use1 SHALL be 1 for types I,R,B,S; use2 for R,B,S; rd_we for R,I,U,J with rd!=0; all others 0.
REQ-016 Scoreboard: NREG-bit busy vector; bit 0 permanently 0.
REQ-017 hazard = (use1 & rs1!=0 & busy[rs1] & !(wb_en & wb_addr==rs1)) | (use2 & rs2!=0 & busy[rs2] & !(wb_en & wb_addr==rs2)) | (rd_we & busy[rd] & !(wb_en & wb_addr==rd)).
REQ-018 in_ready = (!out_valid | out_ready) & !hazard & !flush; issue = in_valid & in_ready.
REQ-019 Operand bypass: if wb_en & wb_addr==rsN & rsN!=0, opN source = wb_data, else rdataN; unused or x0 source yields 0.
REQ-020 On issue, output register SHALL capture op1, op2, in_pc, rd, rd_we, inst_type in the same edge; latency 1 cycle from issue to out_valid.
REQ-021 out_valid next = issue ? 1 : (out_ready ? 0 : out_valid); flush overrides to 0.
REQ-022 Output fields SHALL hold stable while out_valid & !out_ready.
REQ-023 Busy update per edge: clear busy[wb_addr] if wb_en; set busy[rd] on issue with rd_we; set takes priority on same address.
REQ-024 At most one outstanding writer per register (WAW stall per REQ-017).
REQ-025 flush with out_valid & out_rd_we SHALL clear busy[out_rd] (unless same-edge issue, blocked by REQ-018).
REQ-026 stall_cnt increments by 1 each cycle with in_valid & hazard & !flush; saturates at 32'hFFFF_FFFF.

Reset
REQ-027 On rst: out_valid=0, busy=all 0, stall_cnt=0, out_op1/out_op2/out_pc=0, out_rd=0, out_rd_we=0, out_type=0.
REQ-028 rst asserted mid-stall or mid-handshake SHALL abandon the entry; rst dominates flush, issue and wb.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts if out_valid=0 and no hazard.

Verification
REQ-030 R-type rs1=1, rs2=2, rd=3, rdata=5/7, out_ready=1 -> next cycle out_valid=1, op1=5, op2=7, busy[3]=1.
REQ-031 Follow-on I-type rs1=3 while busy[3] and wb_en=0 -> in_ready=0 for 3 cycles, stall_cnt=3; then wb_en, wb_addr=3, wb_data=0x2A -> issue same cycle, op1=0x2A.
REQ-032 rd=0 instruction -> out_rd_we=0, busy unchanged; rs1=0 source -> op1=0 even if rdata1=0xFFFF.
REQ-033 out_ready=0 for 4 cycles with out_valid=1 -> outputs stable, in_ready=0; release -> drains, accepts next.
REQ-034 flush with held entry rd=5 -> out_valid=0, busy[5]=0 next cycle; same-edge wb_addr=5 and issue rd=5 -> busy[5]=1.
REQ-035 rst asserted during stall -> next cycle out_valid=0, busy=0, stall_cnt=0; stall_cnt preload near max -> saturates at 0xFFFFFFFF.
